da_cfg_seq: RTL and testbench
=============================

# da_cfg_seq

Configuration sequencer for the AD9788 DAC, upstream of the SPI serializer. It walks a fixed table of instruction words (register address byte plus payload, 16–40 bits). Each word is handed to the serializer as a data/length pair over a valid/ready handshake, and the sequencer waits for the serializer's completion pulse before issuing the next word. It gates the sequence on a filtered clock-manager lock and restarts on lock loss. It reports busy/done/error status to the PC control path.

## Interface
Parameters:
- NUM_ENTRIES, 9: table depth; entries 0..NUM_ENTRIES-1.
- GAP_CYCLES, 4: idle cycles between one word's completion and the next word's issue (CS-high gap).
- LOCK_FILTER, 8: consecutive CLM_LOCK-high cycles required before lock is considered stable.
- TIMEOUT_CYCLES, 64: maximum cycles waiting for cmd_done before the sequence errors.

Ports:
- GCLK  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- CLM_LOCK  in  1  clock-manager lock; asynchronous to nothing, sampled on GCLK.
- START  in  1  single-cycle start request from PC control.
- cmd_valid  out  1  instruction word presented to the serializer.
- cmd_ready  in  1  serializer accepts the word.
- cmd_data  out  40  instruction, right-justified; bit cmd_len-1 is shifted first.
- cmd_len  out  6  bit count: 16, 24, 32 or 40.
- cmd_done  in  1  one-cycle pulse after the serializer's last bit and CS release.
- CFG_BUSY  out  1  sequence in progress.
- CFG_DONE  out  1  all entries issued; level until the next START, lock loss or reset.
- CFG_ERR  out  1  timeout occurred; level until START or reset.
- CFG_IDX  out  8  index of the current or last issued entry.

## Operation
- Reset values: cmd_valid=0, cmd_data=0, cmd_len=16, CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0, CFG_IDX=0, state=IDLE, lock counter=0.
- Lock filter:
  - Saturating counter, 0..LOCK_FILTER, runs in every state.
  - Increments while CLM_LOCK=1 and clears to 0 on any CLM_LOCK=0 cycle.
  - lock_ok = (counter == LOCK_FILTER).
- States: IDLE, LOCKWAIT, ISSUE, WAIT_DONE, GAP, DONE, ERR.
- IDLE, DONE and ERR on START: go to LOCKWAIT, set CFG_IDX=0, clear CFG_DONE and CFG_ERR, assert CFG_BUSY.
- LOCKWAIT: go to ISSUE when lock_ok=1.
- ISSUE:
  - Drive cmd_valid=1 with cmd_data/cmd_len of entry CFG_IDX.
  - On cmd_valid&&cmd_ready, drop cmd_valid and go to WAIT_DONE with the timeout counter cleared.
  - cmd_data and cmd_len stay stable while cmd_valid=1.
- WAIT_DONE:
  - On cmd_done, go to GAP.
  - If the timeout counter reaches TIMEOUT_CYCLES first, go to ERR: CFG_ERR=1, CFG_BUSY=0.
- GAP: count GAP_CYCLES.
  - If CFG_IDX==last enabled entry, go to DONE: CFG_DONE=1, CFG_BUSY=0.
  - Otherwise advance CFG_IDX to the next enabled entry and go to ISSUE.
- Lock loss (CLM_LOCK=0) in LOCKWAIT, ISSUE, WAIT_DONE or GAP:
  - Drop cmd_valid the next cycle, set CFG_IDX=0 and go to LOCKWAIT (full restart).
  - CFG_BUSY stays 1.
- Lock loss in DONE clears CFG_DONE and restarts via LOCKWAIT.
- Lock loss in IDLE or ERR has no effect.
- Simultaneous events:
  - Lock loss beats cmd_done, cmd_ready and timeout.
  - cmd_done in the same cycle as the timeout expiry counts as done.
  - START while CFG_BUSY=1 is ignored.
- cmd_done outside WAIT_DONE is ignored.
- Table contents, index: data/len:
  - 0: 0x0012/16 (soft reset)
  - 1: 0x0006/16
  - 2: 0x010180/24
  - 3: 0x02000C/24
  - 4: 0x0380000400/40
  - 5: 0x046FB3FF/32
  - 6: 0x0A80000000/40
  - 7: 0x890000/24
  - 8: 0x8A00000000/40
- Entries whose leading instruction byte has bit 7 set (7, 8) are read instructions.
- Width rule: cmd_data bits above cmd_len-1 are zero.

## Timing
- START sampled at edge n (lock_ok already 1): LOCKWAIT at n+1, cmd_valid=1 at n+2.
- Accept at edge k: cmd_valid=0 from k+1.
- cmd_done at edge d: the next cmd_valid rises at d+GAP_CYCLES+2, or CFG_DONE rises at d+GAP_CYCLES+1 after the last entry.
- Lock filter: lock_ok rises LOCK_FILTER edges after CLM_LOCK rises.
- Reset assertion forces all outputs to their reset values immediately, regardless of GCLK.

## Configuration
- DA_CFG_READBACK_EN defined: read entries (7, 8) are issued normally; sequence length 9.
- Undefined: read entries are skipped by index advance and never presented; entry 6 is last; sequence length 7.
- CFG_IDX never shows a skipped index.

## Structure
- Package da_cfg_pkg holds:
  - the state enum;
  - the entry record type (data[39:0], len[5:0]);
  - the constant init table;
  - the is_read(entry) function, true when the leading instruction byte has bit 7 set.
- One natural sub-module: da_lock_filter (saturating counter, outputs lock_ok), reusable by the serializer.

## Test plan
- Nominal: hold CLM_LOCK=1 for 10 cycles, pulse START, bench acks cmd_ready immediately and cmd_done 3 cycles later. Expect 9 words in index order, e.g. word 4 = 0x0380000400/40. Expect CFG_DONE=1 after the 9th done plus 5 cycles.
- Backpressure: hold cmd_ready=0 for 20 cycles on entry 2. Expect cmd_valid held with 0x010180/24 unchanged, no timeout.
- Lock loss: drop CLM_LOCK for 1 cycle while in WAIT_DONE of entry 5. Expect cmd_valid low, CFG_IDX=0, re-issue of 0x0012 exactly 8 cycles after CLM_LOCK returns.
- Timeout: never pulse cmd_done after entry 0. Expect CFG_ERR=1 and CFG_BUSY=0 64 cycles after the accept; START then clears CFG_ERR and restarts at entry 0.
- Macro off: expect 7 words, entry 6 last, and no 0x89/0x8A words presented.
- Async reset asserted mid-WAIT_DONE: all outputs return to reset values without a GCLK edge; START ignored until reset deasserts.

Source files
------------

// File: rtl/da_cfg_pkg.sv
// rtl/da_cfg_pkg.sv - AD9788 configuration sequencer types, instruction table and helpers.
package da_cfg_pkg;

    localparam int DATA_W      = 40;
    localparam int LEN_W       = 6;
    localparam int IDX_W       = 8;
    localparam int TABLE_DEPTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCKWAIT,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } entry_t;

    // Address byte plus payload, right-justified; entries 7 and 8 are readbacks.
    localparam entry_t INIT_TABLE [0:TABLE_DEPTH-1] = '{
        '{data: 40'h00_0000_0012, len: 6'd16},
        '{data: 40'h00_0000_0006, len: 6'd16},
        '{data: 40'h00_0001_0180, len: 6'd24},
        '{data: 40'h00_0002_000C, len: 6'd24},
        '{data: 40'h03_8000_0400, len: 6'd40},
        '{data: 40'h00_046F_B3FF, len: 6'd32},
        '{data: 40'h0A_8000_0000, len: 6'd40},
        '{data: 40'h00_0089_0000, len: 6'd24},
        '{data: 40'h8A_0000_0000, len: 6'd40}
    };

    function automatic entry_t entry_at(input logic [IDX_W-1:0] idx);
        entry_t e;
        e = '{data: '0, len: 6'd16};
        if (idx < IDX_W'(TABLE_DEPTH)) begin
            e = INIT_TABLE[idx[3:0]];
        end
        return e;
    endfunction

    function automatic logic is_read(input entry_t e);
        logic [LEN_W-1:0] msb;
        msb = e.len - 6'd1;
        return e.data[msb];
    endfunction

endpackage

// File: rtl/da_lock_filter.sv
// rtl/da_lock_filter.sv - saturating lock debounce; lock_ok after LOCK_FILTER consecutive high cycles.
module da_lock_filter #(
    parameter int LOCK_FILTER = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock,
    output logic lock_ok
);

    localparam int CW = $clog2(LOCK_FILTER + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!lock) begin
            cnt <= '0;
        end else if (cnt != CW'(LOCK_FILTER)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign lock_ok = (cnt == CW'(LOCK_FILTER));

endmodule

// File: rtl/da_cfg_seq.sv
// rtl/da_cfg_seq.sv - AD9788 configuration sequencer feeding the SPI serializer.
// DA_CFG_READBACK_EN: when defined, read entries are issued; otherwise they are skipped.
module da_cfg_seq
    import da_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES    = 9,
    parameter int GAP_CYCLES     = 4,
    parameter int LOCK_FILTER    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              GCLK,
    input  logic              reset,
    input  logic              CLM_LOCK,
    input  logic              START,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_data,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_done,
    output logic              CFG_BUSY,
    output logic              CFG_DONE,
    output logic              CFG_ERR,
    output logic [IDX_W-1:0]  CFG_IDX
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t            state, state_nxt;
    logic              valid_nxt, busy_nxt, done_nxt, err_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [LEN_W-1:0]  len_nxt;
    logic [IDX_W-1:0]  idx_nxt, next_idx;
    logic [TW-1:0]     tcnt, tcnt_nxt;
    logic [GW-1:0]     gcnt, gcnt_nxt;
    logic              has_next, lock_ok, lock_lost;
    entry_t            cur_entry;

    function automatic logic entry_en(input logic [IDX_W-1:0] idx);
`ifdef DA_CFG_READBACK_EN
        return (idx < IDX_W'(NUM_ENTRIES));
`else
        return (idx < IDX_W'(NUM_ENTRIES)) && !is_read(entry_at(idx));
`endif
    endfunction

    da_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .clk    (GCLK),
        .rst_n  (reset),
        .lock   (CLM_LOCK),
        .lock_ok(lock_ok)
    );

    assign cur_entry = entry_at(CFG_IDX);

    // Lowest enabled index above the current one; none means this is the last word.
    always_comb begin
        next_idx = CFG_IDX;
        has_next = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (IDX_W'(i) > CFG_IDX && entry_en(IDX_W'(i))) begin
                next_idx = IDX_W'(i);
                has_next = 1'b1;
            end
        end
    end

    assign lock_lost = !CLM_LOCK && (state == ST_LOCKWAIT || state == ST_ISSUE ||
                                     state == ST_WAIT_DONE || state == ST_GAP ||
                                     state == ST_DONE);

    always_comb begin
        state_nxt = state;
        valid_nxt = cmd_valid;
        data_nxt  = cmd_data;
        len_nxt   = cmd_len;
        busy_nxt  = CFG_BUSY;
        done_nxt  = CFG_DONE;
        err_nxt   = CFG_ERR;
        idx_nxt   = CFG_IDX;
        tcnt_nxt  = tcnt;
        gcnt_nxt  = gcnt;

        if (lock_lost) begin
            state_nxt = ST_LOCKWAIT;
            valid_nxt = 1'b0;
            idx_nxt   = '0;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (START) begin
                        state_nxt = ST_LOCKWAIT;
                        idx_nxt   = '0;
                        done_nxt  = 1'b0;
                        err_nxt   = 1'b0;
                        busy_nxt  = 1'b1;
                    end
                end
                ST_LOCKWAIT: begin
                    // Index is already 0 here, so entry 0 is presented on the way out.
                    if (lock_ok) begin
                        state_nxt = ST_ISSUE;
                        valid_nxt = 1'b1;
                        data_nxt  = cur_entry.data;
                        len_nxt   = cur_entry.len;
                    end
                end
                ST_ISSUE: begin
                    if (!cmd_valid) begin
                        valid_nxt = 1'b1;
                        data_nxt  = cur_entry.data;
                        len_nxt   = cur_entry.len;
                    end else if (cmd_ready) begin
                        valid_nxt = 1'b0;
                        state_nxt = ST_WAIT_DONE;
                        tcnt_nxt  = '0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (cmd_done) begin
                        state_nxt = ST_GAP;
                        gcnt_nxt  = '0;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gcnt == GW'(GAP_CYCLES - 1)) begin
                        if (has_next) begin
                            idx_nxt   = next_idx;
                            state_nxt = ST_ISSUE;
                        end else begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        gcnt_nxt = gcnt + GW'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge GCLK or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            cmd_len   <= 6'd16;
            CFG_BUSY  <= 1'b0;
            CFG_DONE  <= 1'b0;
            CFG_ERR   <= 1'b0;
            CFG_IDX   <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
        end else begin
            state     <= state_nxt;
            cmd_valid <= valid_nxt;
            cmd_data  <= data_nxt;
            cmd_len   <= len_nxt;
            CFG_BUSY  <= busy_nxt;
            CFG_DONE  <= done_nxt;
            CFG_ERR   <= err_nxt;
            CFG_IDX   <= idx_nxt;
            tcnt      <= tcnt_nxt;
            gcnt      <= gcnt_nxt;
        end
    end

endmodule

// File: tb/tb_da_cfg_seq.sv
// tb/tb_da_cfg_seq.sv - directed table-driven bench for da_cfg_seq.
`timescale 1ns/1ps
module tb_da_cfg_seq;

    logic        GCLK = 1'b0;
    logic        reset = 1'b1;
    logic        CLM_LOCK = 1'b0;
    logic        START = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_done = 1'b0;
    logic        cmd_valid;
    logic [39:0] cmd_data;
    logic [5:0]  cmd_len;
    logic        CFG_BUSY, CFG_DONE, CFG_ERR;
    logic [7:0]  CFG_IDX;

    int n_checks = 0;
    int n_fail = 0;
    int read_words = 0;
    int n_words;

    typedef struct {
        logic [7:0]  idx;
        logic [39:0] data;
        logic [5:0]  len;
    } vec_t;
    vec_t vec [9];

    always #5 GCLK = ~GCLK;

    da_cfg_seq dut (
        .GCLK     (GCLK),
        .reset    (reset),
        .CLM_LOCK (CLM_LOCK),
        .START    (START),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
        .cmd_done (cmd_done),
        .CFG_BUSY (CFG_BUSY),
        .CFG_DONE (CFG_DONE),
        .CFG_ERR  (CFG_ERR),
        .CFG_IDX  (CFG_IDX)
    );

    always @(posedge GCLK) begin
        if (reset && cmd_valid && cmd_data[cmd_len - 6'd1]) read_words++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge GCLK);
        @(negedge GCLK);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_data"}, cmd_data, 0);
        check({tag, "_len"}, cmd_len, 16);
        check({tag, "_busy"}, CFG_BUSY, 0);
        check({tag, "_done"}, CFG_DONE, 0);
        check({tag, "_err"}, CFG_ERR, 0);
        check({tag, "_idx"}, CFG_IDX, 0);
    endtask

    // done_lat == 0 leaves the word outstanding in WAIT_DONE.
    task automatic serve_word(input int k, input int hold, input int done_lat);
        int n = 0;
        bit stable = 1'b1;
        while (!cmd_valid && n < 30) begin
            tick();
            n++;
        end
        check("valid_seen", cmd_valid, 1);
        check("word_data", cmd_data, vec[k].data);
        check("word_len", cmd_len, vec[k].len);
        check("word_idx", CFG_IDX, vec[k].idx);
        check("width_rule", 64'(cmd_data) >> cmd_len, 0);
        for (int i = 0; i < hold; i++) begin
            START = (i == 0);
            tick();
            START = 1'b0;
            if (!cmd_valid || cmd_data !== vec[k].data || cmd_len !== vec[k].len ||
                CFG_IDX !== vec[k].idx || CFG_ERR !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check("backpressure_stable", stable, 1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("drop_after_accept", cmd_valid, 0);
        if (done_lat > 0) begin
            repeat (done_lat - 1) tick();
            cmd_done = 1'b1;
            tick();
            cmd_done = 1'b0;
            if (k == n_words - 1) begin
                repeat (3) tick();
                check("done_not_early", CFG_DONE, 0);
                tick();
                check("done_rise", CFG_DONE, 1);
                check("busy_at_done", CFG_BUSY, 0);
                check("idx_at_done", CFG_IDX, vec[k].idx);
            end else begin
                repeat (4) tick();
                check("gap_low", cmd_valid, 0);
                tick();
                check("gap_rise", cmd_valid, 1);
            end
        end
    endtask

    task automatic run_all();
        for (int k = 0; k < n_words; k++) serve_word(k, 0, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec[0] = '{8'd0, 40'h00_0000_0012, 6'd16};
        vec[1] = '{8'd1, 40'h00_0000_0006, 6'd16};
        vec[2] = '{8'd2, 40'h00_0001_0180, 6'd24};
        vec[3] = '{8'd3, 40'h00_0002_000C, 6'd24};
        vec[4] = '{8'd4, 40'h03_8000_0400, 6'd40};
        vec[5] = '{8'd5, 40'h00_046F_B3FF, 6'd32};
        vec[6] = '{8'd6, 40'h0A_8000_0000, 6'd40};
        vec[7] = '{8'd7, 40'h00_0089_0000, 6'd24};
        vec[8] = '{8'd8, 40'h8A_0000_0000, 6'd40};
`ifdef DA_CFG_READBACK_EN
        n_words = 9;
`else
        n_words = 7;
`endif

        #1 reset = 1'b0;
        #1 check_reset_vals("reset");
        @(negedge GCLK);
        reset = 1'b1;
        CLM_LOCK = 1'b1;
        repeat (10) tick();

        // Nominal sequence; entry 2 is held off by cmd_ready=0 for 20 cycles.
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", CFG_BUSY, 1);
        check("lockwait_no_valid", cmd_valid, 0);
        tick();
        check("first_issue", cmd_valid, 1);
        for (int k = 0; k < n_words; k++) serve_word(k, (k == 2) ? 20 : 0, 3);
        repeat (3) tick();
        check("done_level", CFG_DONE, 1);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("stray_done_ignored", CFG_DONE, 1);
        check("stray_done_no_valid", cmd_valid, 0);

        // Lock loss while entry 5 waits for completion.
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_clears_done", CFG_DONE, 0);
        for (int k = 0; k < 5; k++) serve_word(k, 0, 3);
        serve_word(5, 0, 0);
        CLM_LOCK = 1'b0;
        tick();
        CLM_LOCK = 1'b1;
        check("lockloss_valid", cmd_valid, 0);
        check("lockloss_idx", CFG_IDX, 0);
        check("lockloss_busy", CFG_BUSY, 1);
        repeat (8) tick();
        check("relock_not_early", cmd_valid, 0);
        tick();
        check("relock_issue", cmd_valid, 1);
        check("relock_data", cmd_data, 40'h12);
        run_all();

        // Lock loss in DONE restarts the sequence.
        CLM_LOCK = 1'b0;
        tick();
        CLM_LOCK = 1'b1;
        check("done_lockloss_done", CFG_DONE, 0);
        check("done_lockloss_busy", CFG_BUSY, 1);

        // Timeout: entry 0 accepted but never completed.
        serve_word(0, 0, 0);
        repeat (63) tick();
        check("timeout_not_early", CFG_ERR, 0);
        tick();
        check("timeout_err", CFG_ERR, 1);
        check("timeout_busy", CFG_BUSY, 0);
        CLM_LOCK = 1'b0;
        tick();
        CLM_LOCK = 1'b1;
        check("err_lockloss_ignored", CFG_ERR, 1);
        check("err_lockloss_busy", CFG_BUSY, 0);
        repeat (10) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_clears_err", CFG_ERR, 0);
        check("restart_busy", CFG_BUSY, 1);
        check("restart_idx", CFG_IDX, 0);

        // Asynchronous reset while entry 1 waits for completion.
        serve_word(0, 0, 3);
        serve_word(1, 0, 0);
        #2 reset = 1'b0;
        #1 check_reset_vals("async_reset");
        START = 1'b1;
        tick();
        START = 1'b0;
        reset = 1'b1;
        tick();
        check("start_in_reset_busy", CFG_BUSY, 0);
        check("start_in_reset_valid", cmd_valid, 0);

`ifdef DA_CFG_READBACK_EN
        check("read_words_present", read_words > 0, 1);
`else
        check("read_words_absent", read_words, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
